// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode, load-use hazard detection and ID/EX pipeline register.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        id_stall,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1,
  output logic [31:0] ex_rs2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1_addr,
  output logic [4:0]  ex_rs2_addr,
  output logic [2:0]  ex_funct3,
  output logic [3:0]  ex_alu_op,
  output logic        ex_src_a_pc,
  output logic        ex_src_b_imm,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_jalr,
  output logic        ex_illegal
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd, rs1a, rs2a;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src_a_pc, src_b_imm, mem_read, mem_write, reg_write, branch, jump, jalr, illegal;
  } ex_t;
  ex_t r_ex, w_ex;
  logic [31:0] w_i;
  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rd;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_op;
  logic w_illegal, w_ok, w_hazard, w_rs1_used, w_rs2_used;
  logic [31:0] w_imm;
  logic [3:0] w_alu_rr, w_alu;
  assign w_i = if_instr;
  assign w_opc = w_i[6:0];
  assign w_f3 = w_i[14:12];
  assign w_f7 = w_i[31:25];
  assign w_rd = w_i[11:7];
  assign rs1_addr = w_i[19:15];
  assign rs2_addr = w_i[24:20];
  assign w_lui   = w_opc == 7'b0110111;
  assign w_auipc = w_opc == 7'b0010111;
  assign w_jal   = w_opc == 7'b1101111;
  assign w_jalr  = w_opc == 7'b1100111;
  assign w_br    = w_opc == 7'b1100011;
  assign w_ld    = w_opc == 7'b0000011;
  assign w_st    = w_opc == 7'b0100011;
  assign w_opi   = w_opc == 7'b0010011;
  assign w_op    = w_opc == 7'b0110011;
  assign w_illegal = ~(w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_opi | w_op)
    | (w_op & ~(w_f7 == 7'h00 | (w_f7 == 7'h20 & (w_f3 == 3'd0 | w_f3 == 3'd5))))
    | (w_opi & ((w_f3 == 3'd1 & w_f7 != 7'h00) | (w_f3 == 3'd5 & w_f7 != 7'h00 & w_f7 != 7'h20)))
    | (w_jalr & w_f3 != 3'd0) | (w_br & (w_f3 == 3'd2 | w_f3 == 3'd3))
    | (w_ld & (w_f3 == 3'd3 | w_f3 > 3'd5)) | (w_st & w_f3 > 3'd2);
  assign w_imm = (w_opi | w_ld | w_jalr) ? {{20{w_i[31]}}, w_i[31:20]} :
                 w_st ? {{20{w_i[31]}}, w_i[31:25], w_i[11:7]} :
                 w_br ? {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0} :
                 (w_lui | w_auipc) ? {w_i[31:12], 12'b0} :
                 w_jal ? {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0} : 32'd0;
  always_comb begin
    case (w_f3)
      3'd0: w_alu_rr = (w_op & w_f7 == 7'h20) ? 4'd1 : 4'd0;
      3'd1: w_alu_rr = 4'd2;
      3'd2: w_alu_rr = 4'd3;
      3'd3: w_alu_rr = 4'd4;
      3'd4: w_alu_rr = 4'd5;
      3'd5: w_alu_rr = (w_f7 == 7'h20) ? 4'd7 : 4'd6;
      3'd6: w_alu_rr = 4'd8;
      default: w_alu_rr = 4'd9;
    endcase
  end
  assign w_alu = (w_op | w_opi) ? w_alu_rr : w_br ? 4'd1 : w_lui ? 4'd10 : 4'd0;
  assign w_ok = if_valid & ~w_illegal;
  assign w_rs1_used = ~(w_lui | w_auipc | w_jal);
  assign w_rs2_used = w_op | w_st | w_br;
  assign w_hazard = if_valid & r_ex.valid & r_ex.mem_read & r_ex.rd != 5'd0 &
    ((w_rs1_used & r_ex.rd == rs1_addr) | (w_rs2_used & r_ex.rd == rs2_addr));
  assign id_stall = w_hazard & ~flush;
  always_comb begin
    w_ex = '0;
    w_ex.valid = if_valid;
    w_ex.pc = if_pc;
    w_ex.rs1 = rs1_data;
    w_ex.rs2 = rs2_data;
    w_ex.imm = w_imm;
    w_ex.rd = w_rd;
    w_ex.rs1a = rs1_addr;
    w_ex.rs2a = rs2_addr;
    w_ex.f3 = w_f3;
    w_ex.alu = w_alu;
    w_ex.src_a_pc = w_auipc | w_jal | w_jalr;
    w_ex.src_b_imm = w_opi | w_ld | w_st | w_lui | w_auipc | w_jalr;
    w_ex.mem_read = w_ok & w_ld;
    w_ex.mem_write = w_ok & w_st;
    w_ex.reg_write = w_ok & w_rd != 5'd0 & (w_lui | w_auipc | w_jal | w_jalr | w_ld | w_opi | w_op);
    w_ex.branch = w_ok & w_br;
    w_ex.jump = w_ok & (w_jal | w_jalr);
    w_ex.jalr = w_ok & w_jalr;
    w_ex.illegal = if_valid & w_illegal;
  end
  // reset, flush and load-use all collapse to an all-zero bubble
  always_ff @(posedge clk)
    r_ex <= (rst | flush | w_hazard) ? '0 : w_ex;
  assign ex_valid = r_ex.valid;
  assign ex_pc = r_ex.pc;
  assign ex_rs1 = r_ex.rs1;
  assign ex_rs2 = r_ex.rs2;
  assign ex_imm = r_ex.imm;
  assign ex_rd = r_ex.rd;
  assign ex_rs1_addr = r_ex.rs1a;
  assign ex_rs2_addr = r_ex.rs2a;
  assign ex_funct3 = r_ex.f3;
  assign ex_alu_op = r_ex.alu;
  assign ex_src_a_pc = r_ex.src_a_pc;
  assign ex_src_b_imm = r_ex.src_b_imm;
  assign ex_mem_read = r_ex.mem_read;
  assign ex_mem_write = r_ex.mem_write;
  assign ex_reg_write = r_ex.reg_write;
  assign ex_branch = r_ex.branch;
  assign ex_jump = r_ex.jump;
  assign ex_jalr = r_ex.jalr;
  assign ex_illegal = r_ex.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of decode, hazard stall, flush and reset of id_ex_stage.
module tb_id_ex_stage;
  logic clk = 1'b0, rst, if_valid, flush, id_stall;
  logic [31:0] if_instr, if_pc, rs1_data, rs2_data;
  logic [4:0] rs1_addr, rs2_addr;
  logic ex_valid, ex_src_a_pc, ex_src_b_imm, ex_mem_read, ex_mem_write, ex_reg_write;
  logic ex_branch, ex_jump, ex_jalr, ex_illegal;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [4:0] ex_rd, ex_rs1_addr, ex_rs2_addr;
  logic [2:0] ex_funct3;
  logic [3:0] ex_alu_op;
  logic wr_en;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  // register file model: xN holds 0x1000+N, x0 reads 0, same-cycle write bypass
  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (wr_en && wr_addr == a) ? wr_data : 32'h1000 + {27'd0, a};
  endfunction
  assign rs1_data = rf(rs1_addr);
  assign rs2_data = rf(rs2_addr);
  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .id_stall(id_stall), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_funct3(ex_funct3),
    .ex_alu_op(ex_alu_op), .ex_src_a_pc(ex_src_a_pc), .ex_src_b_imm(ex_src_b_imm),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_illegal(ex_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] ctl;
    return {ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal};
  endfunction
  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100;
    step; step;
    chk("rst_valid", {31'd0, ex_valid}, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_rd", {27'd0, ex_rd}, 0);
    chk("rst_ctl", {25'd0, ctl()}, 0);
    chk("rst_alu", {28'd0, ex_alu_op}, 0);
    chk("rst_pc", ex_pc, 0);
    rst = 1'b0;
    step;
    chk("addi_valid", {31'd0, ex_valid}, 1);
    chk("addi_imm", ex_imm, 5);
    chk("addi_rd", {27'd0, ex_rd}, 1);
    chk("addi_rw", {31'd0, ex_reg_write}, 1);
    chk("addi_bimm", {31'd0, ex_src_b_imm}, 1);
    chk("addi_alu", {28'd0, ex_alu_op}, 0);
    chk("addi_pc", ex_pc, 32'h100);
    if_instr = 32'hFE20AE23; if_pc = 32'h104;
    step;
    chk("sw_imm", ex_imm, 32'hFFFFFFFC);
    chk("sw_ctl", {25'd0, ctl()}, 32'b0100000);
    chk("sw_rs2", ex_rs2, 32'h1002);
    chk("sw_f3", {29'd0, ex_funct3}, 2);
    if_instr = 32'h123452B7;
    step;
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_alu", {28'd0, ex_alu_op}, 10);
    chk("lui_rw", {31'd0, ex_reg_write}, 1);
    if_instr = 32'h4030D213;
    step;
    chk("srai_alu", {28'd0, ex_alu_op}, 7);
    chk("srai_imm", ex_imm, 32'h403);
    if_instr = 32'h00208863;
    step;
    chk("beq_imm", ex_imm, 16);
    chk("beq_alu", {28'd0, ex_alu_op}, 1);
    chk("beq_ctl", {25'd0, ctl()}, 32'b0001000);
    if_instr = 32'h0000A103;
    step;
    chk("lw_ctl", {25'd0, ctl()}, 32'b1010000);
    if_instr = 32'h001101B3;
    #1;
    chk("lu_stall", {31'd0, id_stall}, 1);
    step;
    chk("lu_bub_valid", {31'd0, ex_valid}, 0);
    chk("lu_bub_ctl", {25'd0, ctl()}, 0);
    chk("lu_stall_clr", {31'd0, id_stall}, 0);
    step;
    chk("lu_add_valid", {31'd0, ex_valid}, 1);
    chk("lu_add_rs1a", {27'd0, ex_rs1_addr}, 2);
    chk("lu_add_rs1", ex_rs1, 32'h1002);
    chk("lu_add_rd", {27'd0, ex_rd}, 3);
    if_instr = 32'h0000A003;
    step;
    chk("lwx0_rw", {31'd0, ex_reg_write}, 0);
    if_instr = 32'h001001B3;
    #1;
    chk("lwx0_stall", {31'd0, id_stall}, 0);
    if_instr = 32'h0000A103;
    step;
    if_instr = 32'h001101B3; flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, id_stall}, 0);
    step;
    chk("fl_valid", {31'd0, ex_valid}, 0);
    chk("fl_ctl", {25'd0, ctl()}, 0);
    flush = 1'b0;
    if_instr = 32'h000081B3; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hDEADBEEF;
    step;
    chk("byp_rs1", ex_rs1, 32'hDEADBEEF);
    chk("byp_rs2", ex_rs2, 0);
    wr_en = 1'b0;
    if_instr = 32'h00000000;
    step;
    chk("ill_valid", {31'd0, ex_valid}, 1);
    chk("ill_ctl", {25'd0, ctl()}, 1);
    if_valid = 1'b0; if_instr = 32'h00500093;
    step;
    chk("nv_valid", {31'd0, ex_valid}, 0);
    chk("nv_ctl", {25'd0, ctl()}, 0);
    if_valid = 1'b1; if_instr = 32'h0000A103;
    step;
    if_instr = 32'h001101B3; rst = 1'b1;
    #1;
    chk("rs_stall", {31'd0, id_stall}, 1);
    step;
    chk("rs_valid", {31'd0, ex_valid}, 0);
    chk("rs_stall_clr", {31'd0, id_stall}, 0);
    rst = 1'b0;
    step;
    chk("rs_add_valid", {31'd0, ex_valid}, 1);
    chk("rs_add_rw", {31'd0, ex_reg_write}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage plus ID/EX pipeline register for the RV32I pipeline. It takes the fetched instruction from IF/ID and drives the register file read addresses. It samples the register file read data, which already carries same-cycle writeback forwarding and the x0 = 0 rule, then decodes immediates and control and registers everything toward EX. It also owns load-use hazard detection: it stalls IF and inserts a bubble. A flush from branch resolution kills the instruction in ID.

## Interface
Parameters:
- none (RV32I fixed; XLEN = 32)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF/ID holds a live instruction
- if_instr  in  32  instruction word
- if_pc  in  32  PC of if_instr
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
- id_stall  out  1  combinational; hold PC and IF/ID this cycle
- rs1_addr  out  5  combinational, instr[19:15], to register file
- rs2_addr  out  5  combinational, instr[24:20], to register file
- rs1_data  in  32  register file read data, same cycle
- rs2_data  in  32  register file read data, same cycle
- ex_valid  out  1  ID/EX holds a live instruction
- ex_pc  out  32  registered PC
- ex_rs1, ex_rs2  out  32  registered operands
- ex_imm  out  32  registered sign-extended immediate
- ex_rd, ex_rs1_addr, ex_rs2_addr  out  5  registered addresses, for the forwarding unit
- ex_funct3  out  3  registered funct3 (branch/load/store width)
- ex_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- ex_src_a_pc  out  1  ALU A = pc (AUIPC, JAL, JALR link)
- ex_src_b_imm  out  1  ALU B = imm
- ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_jalr  out  1  control
- ex_illegal  out  1  unsupported opcode/funct

## Operation
- Decode is purely combinational from if_instr.
- Immediates: I, S, B, U, J formats are sign-extended to 32 bits. B and J have bit 0 = 0. U is instr[31:12]<<12.
- ALU op by type:
  - R/I-ALU: ADD..AND, chosen by funct3 and funct7[5]. SUB applies only to R-type. SRA applies to R-type, and to I-type when funct7 = 0100000.
  - Load/store/JALR: ADD. Branch: SUB. LUI: PASS_B. AUIPC: ADD with src_a_pc.
- JAL/JALR set reg_write, which EX uses to write back pc+4.
- reg_write is forced to 0 when rd = 0.
- Register use:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by R-type, store and branch only.
- Load-use hazard, combinational:
  - hazard = if_valid & ex_valid & ex_mem_read & ex_rd != 0 & ((rs1 used & ex_rd == rs1_addr) | (rs2 used & ex_rd == rs2_addr)).
- id_stall = hazard & ~flush.
- ID/EX update on each posedge, in priority order:
  1. rst: all ID/EX state cleared.
  2. flush: load a bubble.
  3. hazard: load a bubble.
  4. Otherwise: load the decoded instruction, with ex_valid = if_valid.
- Bubble: ex_valid = 0 and every control bit = 0 (mem_read, mem_write, reg_write, branch, jump, jalr, illegal). Data fields are don't-care but are driven to 0.
- When if_valid = 0, the register still loads, with all control bits = 0.
- Illegal instruction:
  - ex_illegal = 1 and ex_valid = 1.
  - reg_write, mem_read, mem_write, branch and jump are all 0.

## Timing
- Reset value of every ex_* output is 0; ex_alu_op = ADD (0).
- id_stall, rs1_addr and rs2_addr are combinational, valid in the same cycle as if_instr; no reset value.
- Latency: an instruction in IF/ID at cycle N appears on ex_* at cycle N+1.
- Operands are sampled at the cycle-N edge. A writeback at cycle N is captured through the register file bypass.
- Stall lasts exactly 1 cycle per load-use pair. In the following cycle the load has left ID/EX, so the hazard clears.
- flush and hazard in the same cycle: flush wins and id_stall = 0.
- rst asserted during a stall: ID/EX is cleared, and id_stall follows the combinational equation with ex_valid = 0, i.e. it deasserts.

## Test plan
- Reset: rst high 2 cycles with if_instr = 0x00500093 and if_valid = 1 → all ex_* = 0. First cycle after release: ex_valid = 1, ex_imm = 5, ex_rd = 1, ex_reg_write = 1, ex_src_b_imm = 1, ex_alu_op = 0.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) → ex_imm = 0xFFFFFFFC, ex_mem_write = 1, ex_reg_write = 0.
  - lui x5,0x12345 (0x123452B7) → ex_imm = 0x12345000, ex_alu_op = 10.
- Load-use: lw x2,0(x1) (0x0000A103) followed by add x3,x2,x1 (0x001101B3) → id_stall = 1 for one cycle, and the next ex_valid = 0 with all control bits 0. The add then appears with ex_rs1_addr = 2. Repeat with a load to x0 → no stall.
- Flush priority: hold the load-use pair and assert flush in the stall cycle → id_stall = 0 and a bubble in ID/EX.
- Writeback bypass: in the same cycle, wr_en = 1, wr_addr = 1, wr_data = 0xDEADBEEF, and add x3,x1,x0 in ID → ex_rs1 = 0xDEADBEEF and ex_rs2 = 0.
- Illegal: if_instr = 0x00000000 → ex_illegal = 1, ex_valid = 1, all write/mem controls 0.
